// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock divider.
// CLK_DIV_ODD_DUTY_EN selects the 50%-duty odd-divisor high length in half_len().
package clk_div_pkg;

    localparam int NCH_DEF     = 4;
    localparam int DIV_W_DEF   = 8;
    localparam int DIV_MAX_DEF = 255;
    localparam int DIV_RST_DEF = 2;
    localparam int DIV_ILLEGAL = 2;

    // Number of posedge-registered high cycles in a period of n.
    function automatic int unsigned half_len(input int unsigned n);
`ifdef CLK_DIV_ODD_DUTY_EN
        if (n[0] && n > 1)
            return (n - 1) / 2;
        else
            return (n + 1) / 2;
`else
        return (n + 1) / 2;
`endif
    endfunction

    function automatic logic legal_div(input int unsigned n, input int unsigned max_div);
        return (n != 0) && (n <= max_div);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Per-channel enable, divisor-write handshake and divided-clock outputs.
// Master drives enables and writes; slave (the divider) returns clocks, ticks and status.
interface clk_div_multi_if import clk_div_pkg::*; #(
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   en;
    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic [NCH-1:0]   clko;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   err;

    modport master (
        output en, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, clko, tick, err
    );

    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, clko, tick, err
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, queued divisor, output register and bypass mux; clko/tick lag
// the wrapping posedge by clk-to-q, a queued divisor blocks further writes until it applies (CLK_DIV_ODD_DUTY_EN adds a negedge stage).
module clk_div_chan import clk_div_pkg::*; #(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_MAX = DIV_MAX_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             pend_v_o,
    output logic             clko_o,
    output logic             tick_o,
    output logic             err_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_v_q, pend_v_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             byp_q, byp_d;
    logic             at_end;
    logic             wr_legal;
    logic             per_clk;

    always_comb begin
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_v_d   = pend_v_q;
        cnt_d      = cnt_q + ONE;
        err_d      = err_q;
        at_end     = (cnt_q == cur_div_q - ONE);
        tick_d     = en_i && at_end;
        wr_legal   = legal_div(32'(wr_div_i), $unsigned(DIV_MAX));

        // A disabled channel parks at the last count, so queued divisors land immediately.
        if (at_end) begin
            if (pend_v_q) begin
                cur_div_d = pend_div_q;
                pend_v_d  = 1'b0;
            end
            cnt_d = en_i ? '0 : cur_div_d - ONE;
        end

        if (wr_i) begin
            pend_v_d   = 1'b1;
            pend_div_d = wr_legal ? wr_div_i : DIV_W'(DIV_ILLEGAL);
            err_d      = err_q | ~wr_legal;
        end

        byp_d = tick_d && (cur_div_d == ONE);
        pos_d = (cur_div_d != ONE) && (32'(cnt_d) < half_len(32'(cur_div_d)));
    end

    always_ff @(posedge clki or negedge rst) begin
        if (!rst) begin
            cur_div_q  <= DIV_W'(DIV_RST);
            pend_div_q <= DIV_W'(DIV_RST);
            cnt_q      <= DIV_W'(DIV_RST - 1);
            pend_v_q   <= 1'b0;
            pos_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            byp_q      <= 1'b0;
        end else begin
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            cnt_q      <= cnt_d;
            pend_v_q   <= pend_v_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            byp_q      <= byp_d;
        end
    end

`ifdef CLK_DIV_ODD_DUTY_EN
    logic neg_q;

    // Stretches odd periods by half a cycle; even periods never see it.
    always_ff @(negedge clki or negedge rst) begin
        if (!rst)
            neg_q <= 1'b0;
        else
            neg_q <= pos_q & cur_div_q[0];
    end

    assign per_clk = pos_q | neg_q;
`else
    assign per_clk = pos_q;
`endif

    assign clko_o   = byp_q ? clki : per_clk;
    assign tick_o   = tick_q;
    assign err_o    = err_q;
    assign pend_v_o = pend_v_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent clki dividers with a shared divisor-write port; outputs lag the wrap edge by clk-to-q,
// cfg_ready drops for a channel while its divisor is queued (CLK_DIV_ODD_DUTY_EN: 50% odd duty).
module clk_div_multi import clk_div_pkg::*; #(
    parameter int NCH     = NCH_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_MAX = DIV_MAX_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic           clki,
    input  logic           rst,
    clk_div_multi_if.slave bus
);

    logic [NCH-1:0] pend_v;
    logic [NCH-1:0] wr_sel;
    logic [NCH-1:0] clko;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] err;
    logic           ch_ok;

    // Writes to a nonexistent channel are swallowed with ready held high.
    always_comb begin
        ch_ok         = int'(bus.cfg_ch) < NCH;
        bus.cfg_ready = 1'b1;
        wr_sel        = '0;
        if (ch_ok) begin
            bus.cfg_ready      = ~pend_v[bus.cfg_ch];
            wr_sel[bus.cfg_ch] = bus.cfg_valid & ~pend_v[bus.cfg_ch];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DIV_MAX (DIV_MAX),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clki     (clki),
            .rst      (rst),
            .en_i     (bus.en[g]),
            .wr_i     (wr_sel[g]),
            .wr_div_i (bus.cfg_div),
            .pend_v_o (pend_v[g]),
            .clko_o   (clko[g]),
            .tick_o   (tick[g]),
            .err_o    (err[g])
        );
    end

    assign bus.clko = clko;
    assign bus.tick = tick;
    assign bus.err  = err;

endmodule
